// File: rtl/store_split_seq.sv
// Store sequencer: turns one LSU store request into one or two word-aligned
// write beats with byte enables. Stores crossing a word boundary are split
// into two beats when SPLIT_EN is set, otherwise rejected on err_o together
// with illegal sizes.
//
// Handshakes:
//   req side : a request is taken on a cycle where req_valid_i & req_ready_o.
//              req_ready_o is high only in IDLE; the requester holds its
//              request until it is taken.
//   mem side : a beat completes on a cycle where mem_req_o & mem_gnt_i.
//              While mem_req_o is high without a grant, the beat address,
//              data and byte enables hold stable and mem_req_o stays high
//              (only reset can drop it).
module store_split_seq #(
    parameter int unsigned SPLIT_EN = 1,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic [31:0]       req_wdata_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    // Second-beat fields, captured at accept so the beat can be issued
    // without recomputing the lane math from the (no longer held) request.
    logic [ADDR_W-1:0] b1_addr_q, b1_addr_d;
    logic [31:0]       b1_wdata_q, b1_wdata_d;
    logic [3:0]        b1_be_q, b1_be_d;

    logic [1:0]        off;
    logic [3:0]        mask;
    logic [7:0]        be64;
    logic [63:0]       d64;
    logic              illegal;
    logic              crossing;
    logic [ADDR_W-1:0] beat0_addr;

    // Lane placement of the incoming request across a two-word window.
    always_comb begin
        off = req_addr_i[1:0];
        case (req_size_i)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        be64       = {4'b0000, mask} << off;
        d64        = {32'h0000_0000, req_wdata_i} << {off, 3'b000};
        illegal    = (req_size_i == 2'b11);
        crossing   = (be64[7:4] != 4'b0000);
        beat0_addr = {req_addr_i[ADDR_W-1:2], 2'b00};
    end

    assign req_ready_o = (state_q == IDLE);

    // Next-state and next-output computation for the beat sequencer.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        b1_addr_d   = b1_addr_q;
        b1_wdata_d  = b1_wdata_q;
        b1_be_d     = b1_be_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (illegal || (crossing && (SPLIT_EN == 0))) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = beat0_addr;
                        mem_wdata_d = d64[31:0];
                        mem_be_d    = be64[3:0];
                        b1_addr_d   = beat0_addr + ADDR_W'(4);
                        b1_wdata_d  = d64[63:32];
                        b1_be_d     = be64[7:4];
                    end
                end
            end
            BEAT0: begin
                if (mem_gnt_i) begin
                    if (b1_be_q != 4'b0000) begin
                        state_d     = BEAT1;
                        mem_addr_d  = b1_addr_q;
                        mem_wdata_d = b1_wdata_q;
                        mem_be_d    = b1_be_q;
                    end else begin
                        state_d     = IDLE;
                        mem_req_d   = 1'b0;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                        mem_be_d    = '0;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_gnt_i) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                mem_be_d    = '0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any pending beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            b1_addr_q   <= '0;
            b1_wdata_q  <= '0;
            b1_be_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            b1_addr_q   <= b1_addr_d;
            b1_wdata_q  <= b1_wdata_d;
            b1_be_q     <= b1_be_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: doc/store_split_seq.md
Name: store_split_seq

Overview:
Sequencer between the LSU store path and the single-port, word-wide data memory. It accepts one store request per handshake and converts it into one or two word-aligned write beats with byte enables. Stores that cross a 4-byte boundary are split into two beats. Without splitting enabled, such stores, and illegal sizes, are flagged as errors. It sits after execute, and the pipeline stalls on req_ready_o.

Parameters:
SPLIT_EN, 1, 1 = split word-crossing stores into two beats; 0 = flag them on err_o with no memory access
ADDR_W, 32, address width; beat-1 address wraps modulo 2^ADDR_W

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  store request valid
req_ready_o  out  1  sequencer can accept a request
req_addr_i  in  ADDR_W  byte address
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_wdata_i  in  32  store data, LSB-justified
mem_req_o  out  1  write beat valid
mem_gnt_i  in  1  memory accepts the beat this cycle
mem_addr_o  out  ADDR_W  word-aligned beat address, bits [1:0] = 0
mem_wdata_o  out  32  lane-aligned write data
mem_be_o  out  4  byte enables
done_o  out  1  one-cycle pulse: store fully written
err_o  out  1  one-cycle pulse: store rejected, no memory access

Behaviour:
- Reset values: state IDLE; mem_req_o, done_o, err_o = 0; mem_addr_o, mem_wdata_o, mem_be_o = 0; req_ready_o = 1 in the cycle after reset.
- Accept: request is taken when req_valid_i & req_ready_o. req_ready_o = 1 only in IDLE. Address, size and data are latched.
- Lane math:
  - off = addr[1:0]
  - mask = 0001 / 0011 / 1111 for byte / half / word
  - 8-bit be64 = mask << off
  - 64-bit d64 = wdata << 8*off
  - beat0: addr = {addr[ADDR_W-1:2], 2'b00}, be = be64[3:0], data = d64[31:0]
  - beat1: addr = beat0 addr + 4 (wraps), be = be64[7:4], data = d64[63:32]
- Crossing condition: be64[7:4] != 0. A half-word at off 1 is a single beat with be 0110. A beat with be 0000 is never issued.
- States: IDLE, BEAT0, BEAT1.
  - IDLE: on accept, go to BEAT0. Exception: if size = 11, or (crossing & !SPLIT_EN), stay in IDLE and pulse err_o the next cycle.
  - BEAT0: mem_req_o = 1 with beat0 fields. On mem_gnt_i, go to BEAT1 if crossing, else go to IDLE and pulse done_o the next cycle.
  - BEAT1: mem_req_o = 1 with beat1 fields. On mem_gnt_i, go to IDLE and pulse done_o the next cycle.
- Memory handshake: while mem_req_o = 1 and mem_gnt_i = 0, mem_addr_o, mem_wdata_o and mem_be_o hold stable. mem_req_o never drops without a grant, except on reset.
- Outputs when mem_req_o = 0: mem_addr_o, mem_wdata_o and mem_be_o drive 0 (be = 0000 mandatory).
- Latency with mem_gnt_i tied high:
  - single-beat store: accept at T, beat at T+1, done_o at T+2
  - split store: beats at T+1 and T+2, done_o at T+3
- Back-to-back: req_ready_o = 1 in the same cycle done_o or err_o pulses, so a new request can be accepted in that cycle. Sustained throughput for a single-beat store is one store per 2 cycles.
- done_o and err_o are never high together, and each pulses exactly once per accepted request.
- Reset mid-operation: the pending beat is abandoned. Next cycle: IDLE, mem_req_o = 0, and no done_o or err_o for the aborted store.
- req_valid_i outside IDLE is ignored; no request is lost, because the requester must hold it until ready.

Test Plan:
1. Aligned SW, addr 0x100, data 0xDEADBEEF, gnt high -> one beat: addr 0x100, be 1111, data 0xDEADBEEF; done_o at T+2.
2. SB, addr 0x203, data 0x000000A5 -> one beat: addr 0x200, be 1000, data 0xA5000000; done_o pulses.
3. SW, addr 0x101, data 0x11223344, SPLIT_EN=1 -> beat0: 0x100, be 1110, data 0x22334400; beat1: 0x104, be 0001, data 0x00000011; done_o at T+3.
4. SH, addr 0xFFFFFFFF, data 0xBEEF -> beat0: 0xFFFFFFFC, be 1000, data 0xEF000000; beat1 wraps to 0x00000000, be 0001, data 0x000000BE.
5. mem_gnt_i low for 3 cycles during beat1 of test 3 -> mem_req_o and beat1 fields held constant; done_o only after the grant. Repeat, asserting rst_i in the second stall cycle -> mem_req_o = 0 next cycle and no done_o.
6. SPLIT_EN=0: SW at addr 0x102 -> err_o pulse at T+1, no mem_req_o. Any size=11 request -> err_o. SH at addr 0x101 -> single beat with be 0110, no err_o.
